jstk_poll_sched: RTL
====================

Name: jstk_poll_sched

Overview:
- Scheduler that shares one 40-bit SPI transfer engine between the two player joysticks (PmodJSTK, player 0 and player 1) of the Pong design.
- Alternates transactions between players at a fixed poll interval and builds each outgoing frame from that player's LED bits.
- Decodes each returned frame into per-player x/y/button registers with valid flags and update strobes.
- Sits between the game logic (paddle control) and the SPI transfer engine plus chip-select mux.

Parameters:
POLL_CYCLES, 500000, idle clocks between transfers (10 ms at 50 MHz); must be >= 2
CNT_W, 20, width of the poll/timeout counter; must hold POLL_CYCLES-1 and TIMEOUT_CYCLES-1
TIMEOUT_CYCLES, 262143, max clocks in BUSY before abort (used only with JSTK_TIMEOUT_EN)

Ports:
clk50M  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
enable  in  1  polling allowed
led_p0  in  2  {LD2,LD1} for player 0 joystick
led_p1  in  2  {LD2,LD1} for player 1 joystick
xfer_busy  in  1  SPI engine busy
xfer_done  in  1  one-cycle pulse: frame complete, xfer_rx valid this cycle
xfer_rx  in  40  received frame
xfer_start  out  1  one-cycle transfer request
xfer_tx  out  40  frame to send
cs_sel  out  1  target joystick: 0=player 0, 1=player 1
p0_x, p0_y  out  10 each  player 0 position
p0_btn  out  2  player 0 buttons
p0_valid  out  1  player 0 data valid
p0_upd  out  1  one-cycle pulse on player 0 register update
p1_x, p1_y, p1_btn, p1_valid, p1_upd  out  10,10,2,1,1  same for player 1
xfer_err  out  1  one-cycle pulse on timeout abort (JSTK_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: state WAIT; cnt=0; cs_sel=0; xfer_start=0; xfer_tx=0; all x/y/btn=0; valid=0; upd=0; xfer_err=0.
- WAIT:
  - enable=0: cnt held at 0.
  - enable=1: cnt increments each clock; at cnt==POLL_CYCLES-1, cnt clears and state goes to START.
- START:
  - On entry, register xfer_tx = {6'b100000, led_sel[1:0], 32'b0}, where led_sel = cs_sel ? led_p1 : led_p0.
  - xfer_tx is held stable until the next START.
  - When xfer_busy=0: assert xfer_start for exactly one cycle, then go to BUSY.
  - While xfer_busy=1: remain in START with no pulse.
- BUSY:
  - Wait for xfer_done.
  - On xfer_done, capture the selected player's registers on that same edge:
    - x = {rx[25:24], rx[39:32]}
    - y = {rx[9:8], rx[23:16]}
    - btn = rx[2:1]
    - valid <= 1
  - The selected player's upd is high for the cycle after the capture edge.
  - On the same capture edge, toggle cs_sel and go to WAIT.
- cs_sel changes only on BUSY exit, so it is stable from START entry through xfer_done.
- Request-to-start latency: POLL_CYCLES clocks in WAIT, plus 1 clock in START if the engine is idle.
- enable falling in START or BUSY: the current transaction completes normally; the block then idles in WAIT.
- xfer_done outside BUSY: ignored; no register update.
- led_p* changes after START entry: affect the next frame for that player only.
- Reset mid-transfer: immediate return to reset values. The engine is not aborted by this block.

Optional Feature:
Macro JSTK_TIMEOUT_EN.
- Defined:
  - cnt runs in BUSY.
  - At cnt==TIMEOUT_CYCLES-1 without xfer_done: pulse xfer_err for one cycle, clear the selected player's valid, leave its x/y/btn unchanged, toggle cs_sel, clear cnt, go to WAIT.
  - xfer_done on the timeout cycle takes priority: normal capture, no error.
- Undefined: BUSY waits indefinitely; xfer_err is tied 0.

Decomposition:
- Package jstk_pkg holds:
  - FRAME_W=40
  - CMD_HDR=6'b100000
  - state encoding WAIT/START/BUSY
  - frame field bit positions (X_LO 39:32, X_HI 25:24, Y_LO 23:16, Y_HI 9:8, BTN 2:1)
- One natural sub-module: jstk_frame_decode, a pure function of 40-bit rx to {x, y, btn}, instantiated once on xfer_rx.
- The scheduler FSM, counter and per-player registers stay in the top.

Test Plan:
- POLL_CYCLES=8, enable=1, engine model returns done 50 clocks after start:
  - first xfer_start at clock 9 after reset release, with cs_sel=0.
  - second start 8 WAIT clocks + 1 after the first done, with cs_sel=1.
- rx=40'hA5_00_3C_00_06 on player 0:
  - p0_x=10'h0A5, p0_y=10'h03C, p0_btn=2'b11, p0_valid=1.
  - p0_upd pulses once; all p1 outputs unchanged.
- led_p1=2'b10 → player 1 xfer_tx=40'h82_0000_0000. led_p0=2'b01 → player 0 frame 40'h81_0000_0000.
- xfer_busy held high 20 cycles in START:
  - no xfer_start during busy.
  - exactly one pulse the cycle after busy drops.
- enable dropped mid-BUSY:
  - transfer captured on done.
  - no further xfer_start while enable=0.
  - restart exactly POLL_CYCLES after re-enable.
- JSTK_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done:
  - xfer_err pulses 16 clocks after start.
  - p0_valid cleared; cs_sel toggles to 1.
  - reset asserted mid-BUSY returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame field layout for the joystick poll scheduler.
package jstk_pkg;

   localparam int unsigned FRAME_W = 40;
   localparam int unsigned POS_W   = 10;
   localparam int unsigned BTN_W   = 2;
   localparam int unsigned LED_W   = 2;
   localparam int unsigned HDR_W   = 6;

   localparam logic [HDR_W-1:0] CMD_HDR = 6'b100000;

   localparam int unsigned X_LO_MSB = 39;
   localparam int unsigned X_LO_LSB = 32;
   localparam int unsigned X_HI_MSB = 25;
   localparam int unsigned X_HI_LSB = 24;
   localparam int unsigned Y_LO_MSB = 23;
   localparam int unsigned Y_LO_LSB = 16;
   localparam int unsigned Y_HI_MSB = 9;
   localparam int unsigned Y_HI_LSB = 8;
   localparam int unsigned BTN_MSB  = 2;
   localparam int unsigned BTN_LSB  = 1;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic [BTN_W-1:0] btn;
   } joy_t;

   // Outgoing command frame: header, LED bits, zero padding.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [LED_W-1:0] led);
      return {CMD_HDR, led, (FRAME_W-HDR_W-LED_W)'(0)};
   endfunction

endpackage

// File: rtl/jstk_frame_decode.sv
// Pure decode of a returned 40-bit joystick frame into x/y/button fields.
module jstk_frame_decode
   import jstk_pkg::*;
(
   input  logic [FRAME_W-1:0] rx,
   output joy_t               joy
);

   assign joy.x   = {rx[X_HI_MSB:X_HI_LSB], rx[X_LO_MSB:X_LO_LSB]};
   assign joy.y   = {rx[Y_HI_MSB:Y_HI_LSB], rx[Y_LO_MSB:Y_LO_LSB]};
   assign joy.btn = rx[BTN_MSB:BTN_LSB];

   // Reserved/status bits of the frame carry nothing the game uses.
   logic unused_bits;
   assign unused_bits = ^{rx[31:26], rx[15:10], rx[7:3], rx[0]};

endmodule

// File: rtl/jstk_poll_sched.sv
// Alternating two-player joystick poller sharing one SPI transfer engine.
// Optional BUSY timeout abort is built when JSTK_TIMEOUT_EN is defined.
module jstk_poll_sched
   import jstk_pkg::*;
#(
   parameter int unsigned POLL_CYCLES    = 500000,
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned TIMEOUT_CYCLES = 262143
) (
   input  logic               clk50M,
   input  logic               rst,
   input  logic               enable,
   input  logic [LED_W-1:0]   led_p0,
   input  logic [LED_W-1:0]   led_p1,
   input  logic               xfer_busy,
   input  logic               xfer_done,
   input  logic [FRAME_W-1:0] xfer_rx,
   output logic               xfer_start,
   output logic [FRAME_W-1:0] xfer_tx,
   output logic               cs_sel,
   output logic [POS_W-1:0]   p0_x,
   output logic [POS_W-1:0]   p0_y,
   output logic [BTN_W-1:0]   p0_btn,
   output logic               p0_valid,
   output logic               p0_upd,
   output logic [POS_W-1:0]   p1_x,
   output logic [POS_W-1:0]   p1_y,
   output logic [BTN_W-1:0]   p1_btn,
   output logic               p1_valid,
   output logic               p1_upd,
   output logic               xfer_err
);

   if (POLL_CYCLES < 2) begin : g_poll_chk
      $error("POLL_CYCLES must be at least 2");
   end
   if ((((POLL_CYCLES - 1) >> CNT_W) != 0) || (((TIMEOUT_CYCLES - 1) >> CNT_W) != 0)) begin : g_cnt_chk
      $error("CNT_W too narrow for POLL_CYCLES/TIMEOUT_CYCLES");
   end

   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
`ifdef JSTK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   joy_t             rx_joy;

   jstk_frame_decode u_decode (
      .rx  (xfer_rx),
      .joy (rx_joy)
   );

   // Scheduler FSM, poll counter and per-player result registers.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         state      <= ST_WAIT;
         cnt        <= '0;
         cs_sel     <= 1'b0;
         xfer_start <= 1'b0;
         xfer_tx    <= '0;
         p0_x       <= '0;
         p0_y       <= '0;
         p0_btn     <= '0;
         p0_valid   <= 1'b0;
         p0_upd     <= 1'b0;
         p1_x       <= '0;
         p1_y       <= '0;
         p1_btn     <= '0;
         p1_valid   <= 1'b0;
         p1_upd     <= 1'b0;
         xfer_err   <= 1'b0;
      end else begin
         xfer_start <= 1'b0;
         p0_upd     <= 1'b0;
         p1_upd     <= 1'b0;
         xfer_err   <= 1'b0;
         case (state)
            ST_WAIT: begin
               if (!enable) begin
                  cnt <= '0;
               end else if (cnt == POLL_LAST) begin
                  cnt     <= '0;
                  state   <= ST_START;
                  xfer_tx <= build_frame(cs_sel ? led_p1 : led_p0);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_START: begin
               if (!xfer_busy) begin
                  xfer_start <= 1'b1;
                  state      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A done on the timeout cycle still wins over the abort.
               if (xfer_done) begin
                  if (cs_sel) begin
                     p1_x     <= rx_joy.x;
                     p1_y     <= rx_joy.y;
                     p1_btn   <= rx_joy.btn;
                     p1_valid <= 1'b1;
                     p1_upd   <= 1'b1;
                  end else begin
                     p0_x     <= rx_joy.x;
                     p0_y     <= rx_joy.y;
                     p0_btn   <= rx_joy.btn;
                     p0_valid <= 1'b1;
                     p0_upd   <= 1'b1;
                  end
                  cs_sel <= ~cs_sel;
                  cnt    <= '0;
                  state  <= ST_WAIT;
               end
`ifdef JSTK_TIMEOUT_EN
               else if (cnt == TMO_LAST) begin
                  xfer_err <= 1'b1;
                  if (cs_sel) begin
                     p1_valid <= 1'b0;
                  end else begin
                     p0_valid <= 1'b0;
                  end
                  cs_sel <= ~cs_sel;
                  cnt    <= '0;
                  state  <= ST_WAIT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            default: begin
               state <= ST_WAIT;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
